pipeline_hazard_ctrl: RTL and testbench

- Central sequencing unit for the 5-stage pipelined CPU.
- Drives enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- Resolves these conditions: instruction-cache miss, data-cache wait, load-use hazard, taken branch/jump redirect, and halt drain.
- Sits beside the datapath. Consumes hit signals and decoded hazard info; emits per-latch enable/flush.

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing unit for the 5-stage pipeline. It produces the per-latch
//   enable/flush controls and the PC write enable. It resolves I-cache
//   misses, D-cache waits, load-use hazards, EX redirects and halt drain.
//
// Ports
//   CLK, nRST         clock, synchronous active-low reset
//   ihit, dhit        fetch / data access completes this cycle
//   mem_ren, mem_wen  MEM-stage data request
//   ex_memread, ex_rt load in EX and its destination register
//   id_rs, id_rt      source registers of the instruction in ID
//   ex_redirect       taken branch / jump resolved in EX
//   id_halt, wb_halt  halt decoded in ID / halt retiring in WB
//   pc_en, *_en       latch write enables
//   ifid_flush, idex_flush  clear latch to a bubble (dominates its enable)
//   halted            CPU halted
//
// Optional build macro PIPE_PERF_EN adds three 32-bit performance counters:
//   stall_cycles, flush_count and lu_count.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_redirect,
  input  logic             id_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
`ifdef PIPE_PERF_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
  output logic [31:0]      lu_count,
`endif
  output logic             halted
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALT} state_t;

  state_t state, state_nxt;
  logic   drain_flag, drain_flag_nxt;
  logic   memreq, lu, in_drain, freeze;

  assign memreq = mem_ren | mem_wen;
  assign lu     = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  // A DWAIT that was entered while draining must still behave as DRAIN.
  assign in_drain = (state == DRAIN) || ((state == DWAIT) && drain_flag);
  // A DWAIT cycle with no request counts as a completed access.
  assign freeze   = memreq && !dhit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= RUN;
      drain_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_flag <= drain_flag_nxt;
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    state_nxt  = state;

    if (state == HALT) begin
      halted = 1'b1;
    end else if (freeze) begin
      state_nxt = DWAIT;
    end else begin
      state_nxt = in_drain ? DRAIN : RUN;
      exmem_en  = 1'b1;
      memwb_en  = 1'b1;
      // The halt is older than any branch in EX, so redirects are dropped in drain.
      if (ex_redirect && !in_drain) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu || !ihit) begin
        idex_flush = 1'b1;
      end else begin
        idex_en = 1'b1;
        if (in_drain) begin
          // Only bubbles may follow the halt.
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (id_halt) state_nxt = DRAIN;
        end
      end
    end

    // WB retires on its own, so the halt wins even over a dmem stall.
    if (state != HALT && wb_halt) state_nxt = HALT;

    drain_flag_nxt = (state_nxt == DRAIN) || ((state_nxt == DWAIT) && in_drain);

    if (!nRST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      halted     = 1'b0;
    end
  end

`ifdef PIPE_PERF_EN
  // Events are decoded from the outputs. A taken redirect is the only case
  // that has both pc_en and ifid_flush set. A load-use bubble is an ID/EX
  // flush without an IF/ID flush while lu holds, because lu outranks !ihit.
  logic ev_redirect, ev_lu;
  assign ev_redirect = pc_en && ifid_flush;
  assign ev_lu       = idex_flush && !ifid_flush && lu;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      lu_count     <= '0;
    end else if (state != HALT) begin
      if (!pc_en)      stall_cycles <= stall_cycles + 32'd1;
      if (ev_redirect) flush_count  <= flush_count + 32'd1;
      if (ev_lu)       lu_count     <= lu_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, mem_ren, mem_wen, ex_memread, ex_redirect, id_halt, wb_halt;
  logic [REG_W-1:0] ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_count, lu_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .ex_redirect(ex_redirect), .id_halt(id_halt), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
`ifdef PIPE_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count),
`endif
    .halted(halted)
  );

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
  logic [7:0] outs;
  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};

  localparam logic [7:0] ZERO  = 8'b0000_0000;
  localparam logic [7:0] NORM  = 8'b1101_0110;
  localparam logic [7:0] STALL = 8'b0000_1110;  // idex_en is don't-care
  localparam logic [7:0] M_STL = 8'b1110_1111;
  localparam logic [7:0] REDIR = 8'b1010_1110;  // ifid_en, idex_en are don't-care
  localparam logic [7:0] M_RED = 8'b1010_1111;
  localparam logic [7:0] DRN   = 8'b0011_0110;  // ifid_en is don't-care
  localparam logic [7:0] M_DRN = 8'b1011_1111;
  localparam logic [7:0] HLT   = 8'b0000_0001;
  localparam logic [7:0] ALL   = 8'hFF;

  task automatic chk(input string tag, input logic [7:0] exp, input logic [7:0] mask);
    tests++;
    assert ((outs & mask) === (exp & mask))
      else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b mask=%b", tag, outs, exp, mask);
      end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Move to just after the next rising edge; inputs are then driven and
  // outputs checked one time unit later.
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_ren = 0; mem_wen = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; ex_redirect = 0; id_halt = 0; wb_halt = 0;
  endtask

  initial begin
    nRST = 0; idle();
    #1 chk("reset_outputs", ZERO, ALL);
    nxt(); nxt();

    // first cycle out of reset
    nRST = 1; #1 chk("first_run", NORM, ALL);

    // load-use via rs
    nxt(); ex_memread = 1; ex_rt = 8; id_rs = 8; #1 chk("lu_rs", STALL, M_STL);
    nxt(); ex_memread = 0; #1 chk("lu_clear", NORM, ALL);
    // r0 never hazards
    nxt(); ex_memread = 1; ex_rt = 0; id_rs = 0; #1 chk("lu_r0", NORM, ALL);
    // load-use via rt
    nxt(); ex_rt = 5; id_rt = 5; id_rs = 3; #1 chk("lu_rt", STALL, M_STL);
    nxt(); idle(); ihit = 0; #1 chk("imiss", STALL, M_STL);
    // redirect beats lu and ignores ihit
    nxt(); ex_redirect = 1; ex_memread = 1; ex_rt = 8; id_rs = 8; ihit = 0;
    #1 chk("redirect_over_lu", REDIR, M_RED);

    // dmem wait: 3 freeze cycles, one advance, then normal
    nxt(); idle(); mem_ren = 1; #1 chk("dwait_1", ZERO, ALL);
    nxt(); #1 chk("dwait_2", ZERO, ALL);
    nxt(); #1 chk("dwait_3", ZERO, ALL);
    nxt(); dhit = 1; #1 chk("dwait_done", NORM, ALL);
    nxt(); idle(); #1 chk("dwait_back_run", NORM, ALL);
    // DWAIT with no request completes immediately
    nxt(); mem_wen = 1; #1 chk("dwait_wen", ZERO, ALL);
    nxt(); mem_wen = 0; #1 chk("dwait_noreq", NORM, ALL);

    // reset mid-DWAIT
    nxt(); mem_ren = 1; #1 chk("pre_rst_dwait", ZERO, ALL);
    nxt(); nRST = 0; #1 chk("rst_in_dwait", ZERO, ALL);
    nxt(); nRST = 1; idle(); #1 chk("after_rst_dwait", NORM, ALL);

    // reset mid-drain returns to RUN
    nxt(); id_halt = 1; #1 chk("halt_in_id_a", NORM, ALL);
    nxt(); id_halt = 0; #1 chk("drain_a", DRN, M_DRN);
    nxt(); nRST = 0; #1 chk("rst_in_drain", ZERO, ALL);
    nxt(); nRST = 1; #1 chk("after_rst_drain", NORM, ALL);

    // halt drain, redirect ignored, dmem stall while draining
    nxt(); id_halt = 1; #1 chk("halt_in_id", NORM, ALL);
    nxt(); id_halt = 0; #1 chk("drain_1", DRN, M_DRN);
    nxt(); ex_redirect = 1; #1 chk("drain_2_redirect_ignored", DRN, M_DRN);
    nxt(); ex_redirect = 0; mem_ren = 1; #1 chk("drain_dstall", ZERO, ALL);
    nxt(); dhit = 1; wb_halt = 1; #1 chk("drain_3_resume", DRN, M_DRN);
    nxt(); idle();
    for (int i = 0; i < 20; i++) begin
      ex_redirect = i[0]; mem_ren = i[1]; ihit = i[2];
      #1 chk($sformatf("halted_%0d", i), HLT, ALL);
      nxt();
    end
    nRST = 0; #1 chk("rst_from_halt", ZERO, ALL);
    nxt(); nRST = 1; idle(); #1 chk("run_after_halt", NORM, ALL);

    // wb_halt with a concurrent dmem stall still halts
    nxt(); mem_ren = 1; wb_halt = 1; #1 chk("stall_and_wbhalt", ZERO, ALL);
    nxt(); idle(); #1 chk("halt_over_stall", HLT, ALL);

`ifdef PIPE_PERF_EN
    nRST = 0;
    nxt(); nRST = 1; idle();
    chk32("stall_rst", stall_cycles, 0);
    nxt(); ex_memread = 1; ex_rt = 4; id_rs = 4;
    nxt();
    nxt(); ex_memread = 0; ex_redirect = 1;
    nxt(); ex_redirect = 0; mem_ren = 1;
    nxt(); nxt(); nxt();
    nxt(); dhit = 1;
    nxt(); idle();
    nxt(); #1;
    chk32("lu_count", lu_count, 2);
    chk32("flush_count", flush_count, 1);
    chk32("stall_cycles", stall_cycles, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
